// File: rtl/loader_pkg.sv
// Shared types and constants for the framed UART program loader.
// Holds the FSM state encoding, frame marker bytes and default timeout.
package loader_pkg;

  typedef enum logic [2:0] {
    CHECK,
    IDLE,
    ADDR_H,
    ADDR_L,
    LEN,
    DATA,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] SYNC_DATA = 8'h55;
  localparam logic [7:0] SYNC_END  = 8'hAA;

  localparam int TIMEOUT_DEF = 5_000_000;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter for the frame loader.
// Pulses expire once the frame has been idle for CYCLES cycles.
module loader_timeout #(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(CYCLES) + 1;

  logic [CW-1:0] cnt;

  assign expire = active && !clear &&
                  (cnt == CW'(CYCLES - 1));

  // Count idle cycles while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !active) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Framed, checksummed UART program loader feeding RAM port A.
// Optional inter-byte timeout built when LOADER_TIMEOUT_EN is defined.
module uart_frame_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  loadButton,
  input  logic [7:0]            rxByte,
  input  logic                  newByte,
  output logic [ADDR_WIDTH-3:0] wAddr,
  output logic [31:0]           wData,
  output logic                  wNow,
  output logic                  ROMload,
  output logic [7:0]            frameCount,
  output logic                  csumErr,
  output logic                  timeoutErr
);

  localparam int WA = ADDR_WIDTH - 2;

  state_t        state;
  state_t        nxt;
  logic [WA-1:0] ptr;
  logic [8:0]    left;
  logic [1:0]    bcnt;
  logic [7:0]    sum;
  logic [31:0]   word;
  logic          tmo;
  logic          busy;

  assign busy = (state == ADDR_H) || (state == ADDR_L) ||
                (state == LEN)    || (state == DATA)   ||
                (state == CSUM);

  assign ROMload = (state != CHECK) && (state != DONE);

`ifdef LOADER_TIMEOUT_EN
  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .clear  (newByte),
    .active (busy),
    .expire (tmo)
  );

  // Sticky flag for a frame abandoned mid-way.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timeoutErr <= 1'b0;
    end else if (tmo) begin
      timeoutErr <= 1'b1;
    end
  end
`else
  // No counter: an open frame waits forever.
  assign tmo        = (TIMEOUT_CYCLES < 0);
  assign timeoutErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= CHECK;
    end else begin
      state <= nxt;
    end
  end

  // Frame parser next-state.
  always_comb begin
    nxt = state;
    unique case (state)
      CHECK:  nxt = loadButton ? IDLE : DONE;
      IDLE: begin
        if (newByte) begin
          unique case (1'b1)
            (rxByte == SYNC_DATA): nxt = ADDR_H;
            (rxByte == SYNC_END):  nxt = DONE;
            default:               nxt = IDLE;
          endcase
        end
      end
      ADDR_H: if (newByte) nxt = ADDR_L;
      ADDR_L: if (newByte) nxt = LEN;
      LEN:    if (newByte) nxt = DATA;
      DATA: begin
        if (newByte && bcnt == 2'd3 &&
            left == 9'd1) begin
          nxt = CSUM;
        end
      end
      CSUM:   if (newByte) nxt = IDLE;
      DONE:   nxt = DONE;
      default: nxt = CHECK;
    endcase
    if (tmo) nxt = IDLE;
  end

  // Address, word assembly, write strobe and status.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr        <= '0;
      left       <= '0;
      bcnt       <= '0;
      sum        <= '0;
      word       <= '0;
      wAddr      <= '0;
      wData      <= '0;
      wNow       <= 1'b0;
      frameCount <= '0;
      csumErr    <= 1'b0;
    end else begin
      wNow <= 1'b0;
      if (newByte) begin
        unique case (state)
          ADDR_H: begin
            ptr <= WA'({rxByte, 8'h00});
            sum <= rxByte;
          end
          ADDR_L: begin
            ptr[7:0] <= rxByte;
            sum      <= sum + rxByte;
          end
          LEN: begin
            left <= (rxByte == 8'h00) ?
                    9'd256 : {1'b0, rxByte};
            bcnt <= 2'd0;
            sum  <= sum + rxByte;
          end
          DATA: begin
            sum  <= sum + rxByte;
            bcnt <= bcnt + 2'd1;
            word <= {rxByte, word[31:8]};
            if (bcnt == 2'd3) begin
              wNow  <= 1'b1;
              wAddr <= ptr;
              wData <= {rxByte, word[31:8]};
              ptr   <= ptr + WA'(1);
              left  <= left - 9'd1;
            end
          end
          CSUM: begin
            if (sum + rxByte == 8'h00) begin
              if (frameCount != 8'hFF)
                frameCount <= frameCount + 8'd1;
            end else begin
              csumErr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
